// File: rtl/wd_encoder_if.sv
// Host/drive-side signal bundle for the MFM record encoder.
interface wd_encoder_if;
  logic       start;
  logic [7:0] data_in;
  logic       data_last;
  logic       data_req_n;
  logic       mfm_out;
  logic       write_gate;
  logic       done;

  modport master (
    output start, data_in, data_last,
    input  data_req_n, mfm_out, write_gate, done
  );

  modport slave (
    input  start, data_in, data_last,
    output data_req_n, mfm_out, write_gate, done
  );
endinterface

// File: rtl/wd_encoder.sv
// MFM record encoder: gap, sync, A1 mark, ID, host data and postamble as a serial cell stream.
// CELL_CLKS must be at least 2 so the data request can lead the slot boundary by one cycle.
module wd_encoder #(
  parameter logic [7:0]  GAP_LEN   = 8'd12,
  parameter logic [7:0]  SYNC_LEN  = 8'd12,
  parameter logic [7:0]  ID_VAL    = 8'hFE,
  parameter logic [7:0]  POST_LEN  = 8'd3,
  parameter int unsigned CELL_CLKS = 5
) (
  input  logic         clk_50,
  input  logic         reset,
  wd_encoder_if.slave  bus
);

  localparam int unsigned CW        = (CELL_CLKS > 1) ? $clog2(CELL_CLKS) : 1;
  localparam logic [CW-1:0] CELL_LAST = CW'(CELL_CLKS - 1);
  localparam logic [7:0]  GAP_BYTE  = 8'h4E;
  localparam logic [7:0]  SYNC_BYTE = 8'h00;
  localparam logic [7:0]  MARK_BYTE = 8'hA1;

  typedef enum logic [2:0] {IDLE, GAP, SYNC, MARK, ID, DATA, POST} state_t;

  state_t        state;
  state_t        nxt_state;
  logic [CW-1:0] cell_cnt;
  logic [3:0]    cell_idx;
  logic [7:0]    byte_cnt;
  logic [7:0]    nxt_cnt;
  logic [7:0]    nxt_byte;
  logic          nxt_mark;
  logic [15:0]   word;
  logic [15:0]   nxt_word;
  logic [15:0]   first_word;
  logic          prev_d;
  logic          cur_last;
  logic          want_data;
  logic          slot_end;
  logic          pre_end;

  // Cell pair (clock, data) per bit, MSB first; the mark drops the clock of bit 2.
  function automatic logic [15:0] mfm_encode(input logic [7:0] b, input logic p, input logic mark);
    logic [15:0] w;
    logic        pd;
    w  = '0;
    pd = p;
    for (int i = 7; i >= 0; i--) begin
      w[2*i+1] = ~(pd | b[i]);
      w[2*i]   = b[i];
      pd       = b[i];
    end
    if (mark) w[5] = 1'b0;
    return w;
  endfunction

  assign slot_end  = (cell_idx == 4'd15) && (cell_cnt == '0);
  assign pre_end   = (cell_idx == 4'd15) && (cell_cnt == CW'(1));
  assign want_data = (state == ID) || ((state == DATA) && !cur_last);

  // Field sequencing: what the byte slot after the current one carries.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = byte_cnt - 8'd1;
    nxt_byte   = GAP_BYTE;
    nxt_mark   = 1'b0;
    first_word = mfm_encode(GAP_BYTE, 1'b0, 1'b0);
    case (state)
      GAP: begin
        if (byte_cnt == 8'd0) begin
          nxt_state = SYNC;
          nxt_cnt   = SYNC_LEN - 8'd1;
        end
        nxt_byte = (byte_cnt == 8'd0) ? SYNC_BYTE : GAP_BYTE;
      end
      SYNC: begin
        if (byte_cnt == 8'd0) begin
          nxt_state = MARK;
          nxt_byte  = MARK_BYTE;
          nxt_mark  = 1'b1;
        end else begin
          nxt_byte  = SYNC_BYTE;
        end
      end
      MARK: begin
        nxt_state = ID;
        nxt_byte  = ID_VAL;
      end
      ID: begin
        nxt_state = DATA;
        nxt_byte  = bus.data_in;
      end
      DATA: begin
        if (cur_last) begin
          nxt_state = POST;
          nxt_cnt   = POST_LEN - 8'd1;
        end else begin
          nxt_byte  = bus.data_in;
        end
      end
      POST: begin
        if (byte_cnt == 8'd0) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
    nxt_word = mfm_encode(nxt_byte, prev_d, nxt_mark);
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state          <= IDLE;
      cell_cnt       <= '0;
      cell_idx       <= '0;
      byte_cnt       <= '0;
      word           <= '0;
      prev_d         <= 1'b0;
      cur_last       <= 1'b0;
      bus.mfm_out    <= 1'b0;
      bus.write_gate <= 1'b0;
      bus.data_req_n <= 1'b1;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE) begin
        bus.data_req_n <= 1'b1;
        // The done cycle is still IDLE but must not start a new record.
        if (bus.start && !bus.done) begin
          state          <= GAP;
          byte_cnt       <= GAP_LEN - 8'd1;
          word           <= first_word;
          bus.mfm_out    <= first_word[15];
          prev_d         <= GAP_BYTE[0];
          cur_last       <= 1'b0;
          cell_cnt       <= CELL_LAST;
          cell_idx       <= '0;
          bus.write_gate <= 1'b1;
        end
      end else begin
        bus.data_req_n <= !(pre_end && want_data);
        if (cell_cnt != '0) begin
          cell_cnt <= cell_cnt - CW'(1);
        end else begin
          cell_cnt <= CELL_LAST;
          cell_idx <= cell_idx + 4'd1;
          if (!slot_end) begin
            bus.mfm_out <= word[14];
            word        <= {word[14:0], 1'b0};
          end else if (nxt_state == IDLE) begin
            state          <= IDLE;
            bus.write_gate <= 1'b0;
            bus.mfm_out    <= 1'b0;
            bus.done       <= 1'b1;
          end else begin
            state       <= nxt_state;
            byte_cnt    <= nxt_cnt;
            word        <= nxt_word;
            bus.mfm_out <= nxt_word[15];
            prev_d      <= nxt_byte[0];
            if ((state == ID) || (state == DATA)) cur_last <= bus.data_last;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wd_encoder.sv
// Directed bench for wd_encoder: short, default and CELL_CLKS=4 configurations behind one selector.
module tb_wd_encoder;

  logic       clk_50;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       data_last;
  int         sel;

  logic o_mfm, o_wg, o_req_n, o_done;

  int n_cmp;
  int n_bad;

  logic [7:0]  data_q[$];
  logic        last_q[$];
  int          data_idx;
  logic        cells[$];
  logic [15:0] words[$];
  int          req_pos[$];
  int          rec_len;
  int          done_cnt;
  int          bad_align;

  wd_encoder_if if_s();
  wd_encoder_if if_d();
  wd_encoder_if if_c();

  assign if_s.start = start && (sel == 0);
  assign if_d.start = start && (sel == 1);
  assign if_c.start = start && (sel == 2);
  assign if_s.data_in = data_in;
  assign if_d.data_in = data_in;
  assign if_c.data_in = data_in;
  assign if_s.data_last = data_last;
  assign if_d.data_last = data_last;
  assign if_c.data_last = data_last;

  always_comb begin
    case (sel)
      0:       begin o_mfm = if_s.mfm_out; o_wg = if_s.write_gate; o_req_n = if_s.data_req_n; o_done = if_s.done; end
      1:       begin o_mfm = if_d.mfm_out; o_wg = if_d.write_gate; o_req_n = if_d.data_req_n; o_done = if_d.done; end
      default: begin o_mfm = if_c.mfm_out; o_wg = if_c.write_gate; o_req_n = if_c.data_req_n; o_done = if_c.done; end
    endcase
  end

  wd_encoder #(.GAP_LEN(8'd1), .SYNC_LEN(8'd1), .POST_LEN(8'd1)) u_short (
    .clk_50(clk_50), .reset(reset), .bus(if_s));
  wd_encoder u_dflt (
    .clk_50(clk_50), .reset(reset), .bus(if_d));
  wd_encoder #(.GAP_LEN(8'd1), .SYNC_LEN(8'd1), .POST_LEN(8'd1), .CELL_CLKS(4)) u_c4 (
    .clk_50(clk_50), .reset(reset), .bus(if_c));

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_data();
    data_idx  = 0;
    data_in   = data_q[0];
    data_last = last_q[0];
  endtask

  task automatic pulse_start();
    @(negedge clk_50);
    start = 1'b1;
    @(negedge clk_50);
    start = 1'b0;
  endtask

  // Records one write_gate window cycle by cycle; returns at the negedge of the done cycle
  // (or, with poke, at cycle 0 of the record restarted right after done).
  task automatic capture(input int cc, input bit poke);
    int          t;
    bit          seen;
    logic [15:0] w;
    int          k;
    cells = {}; words = {}; req_pos = {};
    done_cnt = 0; bad_align = 0; rec_len = 0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (o_wg) seen = 1'b1;
      else @(negedge clk_50);
    end
    if (!seen) begin
      check("wg_rise_timeout", 32'(o_wg), 32'd1);
      return;
    end
    t = 0;
    while (o_wg && t < 20000) begin
      if (poke) start = 1'b0;
      cells.push_back(o_mfm);
      if (t > 0 && cells[t] != cells[t-1] && (t % cc) != 0) bad_align++;
      if (o_done) done_cnt++;
      if (!o_req_n) begin
        if (poke && req_pos.size() == 0) start = 1'b1;
        req_pos.push_back(t);
        @(posedge clk_50);
        #1;
        if (data_idx + 1 < data_q.size()) begin
          data_idx++;
          data_in   = data_q[data_idx];
          data_last = last_q[data_idx];
        end
      end
      t++;
      @(negedge clk_50);
    end
    rec_len = t;
    check("done_before_fall", 32'(done_cnt), 32'd0);
    check("done_at_fall", 32'(o_done), 32'd1);
    check("mfm_idle", 32'(o_mfm), 32'd0);
    check("cell_align", 32'(bad_align), 32'd0);
    for (int i = 0; i < rec_len / (16 * cc); i++) begin
      w = '0;
      for (int j = 0; j < 16; j++) begin
        k = (16 * i + j) * cc;
        if (k < cells.size()) w[15-j] = cells[k];
      end
      words.push_back(w);
    end
    if (poke) begin
      start = 1'b1;
      @(negedge clk_50);
      check("start_in_done_ignored", 32'(o_wg), 32'd0);
      check("done_one_cycle", 32'(o_done), 32'd0);
      @(negedge clk_50);
      check("restart_after_done", 32'(o_wg), 32'd1);
      start = 1'b0;
    end else begin
      @(negedge clk_50);
      check("done_one_cycle", 32'(o_done), 32'd0);
    end
  endtask

  task automatic check_short_words(input string tag);
    logic [15:0] exp_w[6];
    exp_w = '{16'h9254, 16'hAAAA, 16'h4489, 16'h5554, 16'h5555, 16'h1254};
    check({tag, "_nwords"}, 32'(words.size()), 32'd6);
    for (int i = 0; i < 6 && i < words.size(); i++)
      check($sformatf("%s_word%0d", tag, i), 32'(words[i]), 32'(exp_w[i]));
  endtask

  bit found;

  initial begin
    n_cmp = 0; n_bad = 0;
    sel = 1; start = 1'b1; reset = 1'b1; data_in = 8'h00; data_last = 1'b0; data_idx = 0;

    // Reset held 3 cycles with start asserted throughout.
    @(posedge clk_50);
    repeat (3) @(negedge clk_50);
    check("rst_mfm", 32'(o_mfm), 32'd0);
    check("rst_wg", 32'(o_wg), 32'd0);
    check("rst_req_n", 32'(o_req_n), 32'd1);
    check("rst_done", 32'(o_done), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk_50);
    check("start_in_reset_ignored", 32'(o_wg), 32'd0);

    // Minimal field lengths, single data byte 0xFF.
    sel = 0;
    data_q = '{8'hFF}; last_q = '{1'b1};
    load_data();
    pulse_start();
    capture(5, 1'b0);
    check("short_len", 32'(rec_len), 32'd480);
    check("short_nreq", 32'(req_pos.size()), 32'd1);
    check_short_words("short");

    // Defaults, three data bytes, start poked in DATA and in the done cycle.
    sel = 1;
    data_q = '{8'h00, 8'h01, 8'h80}; last_q = '{1'b0, 1'b0, 1'b1};
    load_data();
    pulse_start();
    capture(5, 1'b1);
    check("dflt_len", 32'(rec_len), 32'd2560);
    check("dflt_nreq", 32'(req_pos.size()), 32'd3);
    if (req_pos.size() == 3) begin
      check("dflt_req0_pos", 32'(req_pos[0]), 32'd2079);
      check("dflt_req_gap1", 32'(req_pos[1] - req_pos[0]), 32'd80);
      check("dflt_req_gap2", 32'(req_pos[2] - req_pos[1]), 32'd80);
    end
    check("dflt_nwords", 32'(words.size()), 32'd32);
    if (words.size() == 32) begin
      check("dflt_gap0", 32'(words[0]), 32'h9254);
      check("dflt_gap11", 32'(words[11]), 32'h9254);
      check("dflt_sync0", 32'(words[12]), 32'hAAAA);
      check("dflt_mark", 32'(words[24]), 32'h4489);
      check("dflt_id", 32'(words[25]), 32'h5554);
      check("dflt_data0", 32'(words[26]), 32'hAAAA);
      check("dflt_data1", 32'(words[27]), 32'hAAA9);
      check("dflt_data2", 32'(words[28]), 32'h4AAA);
      check("dflt_post0", 32'(words[29]), 32'h9254);
      check("dflt_post2", 32'(words[31]), 32'h9254);
    end
    // The record restarted one cycle after done runs to full length.
    load_data();
    capture(5, 1'b0);
    check("restart_len", 32'(rec_len), 32'd2560);

    // Reset in the middle of DATA.
    load_data();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk_50);
      if (!o_req_n) found = 1'b1;
    end
    check("reach_data", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk_50);
    check("midrst_mfm", 32'(o_mfm), 32'd0);
    check("midrst_wg", 32'(o_wg), 32'd0);
    check("midrst_req_n", 32'(o_req_n), 32'd1);
    check("midrst_done", 32'(o_done), 32'd0);
    reset = 1'b0;
    @(negedge clk_50);
    check("midrst_no_done", 32'(o_done), 32'd0);
    check("midrst_idle", 32'(o_wg), 32'd0);
    load_data();
    pulse_start();
    capture(5, 1'b0);
    check("postrst_len", 32'(rec_len), 32'd2560);
    if (words.size() > 0) check("postrst_word0", 32'(words[0]), 32'h9254);

    // CELL_CLKS = 4: 64 cycles per byte.
    sel = 2;
    data_q = '{8'hFF}; last_q = '{1'b1};
    load_data();
    pulse_start();
    capture(4, 1'b0);
    check("c4_len", 32'(rec_len), 32'd384);
    check("c4_nreq", 32'(req_pos.size()), 32'd1);
    if (req_pos.size() == 1) check("c4_req_pos", 32'(req_pos[0]), 32'd255);
    check_short_words("c4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
